serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b - bin) mod 2^WIDTH one bit per clock, LSB first,
// and reports the final borrow. Operands are captured on an accepted start.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             diff_bit;
  logic             next_borrow;
  logic             last_bit;

  // Full-subtractor on the current LSBs of the operand shift registers.
  assign diff_bit    = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
  assign next_borrow = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & borrow_q) | (b_sr_q[0] & borrow_q);
  assign last_bit    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    busy_d   = busy_q;
    done_d   = done_q;

    case (state_q)
      IDLE, DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end

      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_d    = {diff_bit, res_q[WIDTH-1:1]};
        borrow_d = next_borrow;
        cnt_d    = cnt_q + CW'(1);
        // The result bit computed on this edge is the MSB, so publish the whole word now.
        if (last_bit) begin
          diff_d  = {diff_bit, res_q[WIDTH-1:1]};
          bout_d  = next_borrow;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases, exhaustive
// back-to-back sweep and random operations against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [W-1:0] last_diff;
  logic         last_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Runs one operation. Call at a negedge while idle or in the done cycle; returns at the
  // negedge of the done cycle, so a following call starts back-to-back.
  task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                    input bit hold);
    logic [31:0]  raw;
    logic [W-1:0] exp_d;
    logic         exp_b;
    int           n;
    bit           seen;
    raw   = 32'(ai) - 32'(bi) - 32'(ci);
    exp_d = raw[W-1:0];
    exp_b = (int'(ai) < int'(bi) + int'(ci));
    a = ai; b = bi; bin = ci; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    n = 0;
    seen = 0;
    while (n <= 3 * W) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      chk("busy_in_run", 32'(busy), 32'd1);
      chk("diff_held_in_run", 32'(diff), 32'(last_diff));
      if (hold) begin
        a   = W'($urandom_range(0, MAXV));
        b   = W'($urandom_range(0, MAXV));
        bin = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'(W));
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("diff", 32'(diff), 32'(exp_d));
    chk("bout", 32'(bout), 32'(exp_b));
    $display("op a=%h b=%h bin=%0d -> diff=%h bout=%0d (exp %h/%0d) lat=%0d",
             ai, bi, ci, diff, bout, exp_d, exp_b, n);
    last_diff = exp_d;
    last_bout = exp_b;
  endtask

  task automatic idle_cycles(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_diff", 32'(diff), 32'(last_diff));
      chk("idle_bout", 32'(bout), 32'(last_bout));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_diff = '0; last_bout = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Basic, underflow and no-borrow cases
    op(4'b0011, 4'b0010, 1'b1, 0);
    idle_cycles(2);
    op(4'b0001, 4'b1000, 1'b1, 0);
    idle_cycles(1);
    op(4'b0111, 4'b1010, 1'b0, 0);
    idle_cycles(1);
    op(4'b1111, 4'b0110, 1'b0, 0);
    idle_cycles(10);

    // Start held high with operands churning during the run
    op(4'b1001, 4'b0011, 1'b1, 1);
    op(4'b0100, 4'b0101, 1'b0, 0);
    idle_cycles(2);

    // Boundary cases
    op(4'b1010, 4'b1010, 1'b0, 0);
    op(4'b0000, 4'b1111, 1'b1, 0);
    idle_cycles(1);

    // Leave a nonzero result, then reset in the middle of a run
    op(4'b0110, 4'b0001, 1'b0, 0);
    idle_cycles(1);
    a = 4'h9; b = 4'h2; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    chk("midrun_rst_diff", 32'(diff), 32'd0);
    chk("midrun_rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_diff = '0;
    last_bout = 1'b0;
    idle_cycles(2 * W);
    op(4'b0000, 4'b1111, 1'b1, 0);
    idle_cycles(1);

    // Exhaustive back-to-back sweep
    for (int ai = 0; ai <= MAXV; ai++)
      for (int bi = 0; bi <= MAXV; bi++)
        for (int ci = 0; ci < 2; ci++)
          op(W'(ai), W'(bi), 1'(ci), 0);
    idle_cycles(1);

    // Random operations with random idle gaps
    for (int i = 0; i < 40; i++) begin
      op(W'($urandom_range(0, MAXV)), W'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)),
         bit'($urandom_range(0, 3) == 0));
      start = 1'b0;
      idle_cycles($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
